// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_I    = 2'd1,
        SIDE_D    = 2'd2
    } side_e;

    localparam int DEF_MAX_D_BURST = 4;
endpackage

// File: rtl/mem_arb_grant.sv
// Data-first priority decision with a starvation guard that hands the port
// to fetch after MAX_D_BURST consecutive data grants.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic can_grant,
    input  logic i_req,
    input  logic d_req,
    output logic i_grant,
    output logic d_grant
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

    logic [3:0] d_burst_cnt;
    logic       starve;

    assign starve = i_req && (d_burst_cnt == MAX_CNT);

    always_comb begin
        d_grant = can_grant & d_req & ~starve;
        i_grant = can_grant & i_req & ~d_grant;
    end

    // Counts only data grants that actually kept a waiting fetch out.
    always_ff @(posedge clk) begin
        if (rst)
            d_burst_cnt <= '0;
        else if (i_grant || !i_req)
            d_burst_cnt <= '0;
        else if (d_grant && d_burst_cnt != MAX_CNT)
            d_burst_cnt <= d_burst_cnt + 4'd1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters.
// Define MEM_ARB_PERF_EN to add the perf_conflict_cnt output.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
`ifdef MEM_ARB_PERF_EN
    ,output logic [31:0]      perf_conflict_cnt
`endif
);
    arb_state_e        state;
    logic              store_q;
    logic [ADDR_W-1:0] addr_q;
    logic              can_grant, done, i_grant, d_grant;

    // A new access may issue when idle or when the outstanding one retires now.
    assign can_grant = ~rst & ((state == IDLE) | mem_ready);
    assign done      = ~rst & (state != IDLE) & mem_ready;

    mem_arb_grant #(.MAX_D_BURST(MAX_D_BURST)) u_grant (
        .clk       (clk),
        .rst       (rst),
        .can_grant (can_grant),
        .i_req     (i_req),
        .d_req     (d_req),
        .i_grant   (i_grant),
        .d_grant   (d_grant)
    );

    always_comb begin
        i_valid   = done & (state == BUSY_I);
        d_valid   = done & (state == BUSY_D);
        i_rdata   = i_valid ? mem_rdata : '0;
        d_rdata   = (d_valid & ~store_q) ? mem_rdata : '0;
        i_stall   = ~rst & i_req & ~i_grant;
        d_stall   = ~rst & d_req & ~d_grant;
        mem_en    = i_grant | d_grant;
        mem_we    = (d_grant & d_we) ? d_be : 4'd0;
        mem_wdata = d_grant ? d_wdata : '0;
        mem_addr  = d_grant ? d_addr : (i_grant ? i_addr : addr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            store_q <= 1'b0;
            addr_q  <= '0;
        end else if (d_grant) begin
            state   <= BUSY_D;
            store_q <= d_we;
            addr_q  <= d_addr;
        end else if (i_grant) begin
            state   <= BUSY_I;
            store_q <= 1'b0;
            addr_q  <= i_addr;
        end else if (done) begin
            state   <= IDLE;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_conflict_cnt <= '0;
        else if (i_req && d_req)
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
`else
    // no conflict counter in this build
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory.
module tb_mem_port_arbiter;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_valid, i_stall, d_valid, d_stall, mem_en;
    logic [3:0]  mem_we;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(32), .MAX_D_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int side; logic [31:0] data; } exp_t;
    exp_t sb[$];

    int tests = 0, failed = 0;

    // reference model: who owns the memory, how many data grants in a row
    int          m_busy = 0;      // 0 none, 1 fetch, 2 data
    logic [31:0] m_addr = '0;
    int          m_run  = 0;
    logic [31:0] m_perf = '0;
    logic [31:0] mem [16];
    bit          hold_i = 0, hold_d = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(15)) << 2;
    endfunction

    task automatic cycle(input int pi, input int pd, input int prdy, input int pwe, input bit do_rst);
        int win;
        bit complete, can;
        @(negedge clk);
        rst = do_rst;
        if (!hold_i) begin
            i_req  = ($urandom_range(99) < pi);
            i_addr = rnd_addr();
        end
        if (!hold_d) begin
            d_req   = ($urandom_range(99) < pd);
            d_we    = ($urandom_range(99) < pwe);
            d_be    = 4'($urandom_range(1, 15));
            d_addr  = rnd_addr();
            d_wdata = $urandom;
        end
        mem_ready = ($urandom_range(99) < prdy);
        mem_rdata = (m_busy != 0) ? mem[m_addr[5:2]] : $urandom;
        #1;
        if (rst) begin
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_i_valid", 32'(i_valid), 0);
            chk("rst_d_valid", 32'(d_valid), 0);
            chk("rst_i_stall", 32'(i_stall), 0);
            chk("rst_d_stall", 32'(d_stall), 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            m_busy = 0; m_run = 0; m_perf = '0;
            hold_i = 0; hold_d = 0;
            sb.delete();
            return;
        end
        complete = (m_busy != 0) && mem_ready;
        can      = (m_busy == 0) || mem_ready;
        win = 0;
        if (can) begin
            if (d_req && !(i_req && m_run == MAXB)) win = 2;
            else if (i_req) win = 1;
        end
        chk("i_valid", 32'(i_valid), 32'(complete && m_busy == 1));
        chk("d_valid", 32'(d_valid), 32'(complete && m_busy == 2));
        chk("mem_en", 32'(mem_en), 32'(win != 0));
        chk("i_stall", 32'(i_stall), 32'(i_req && win != 1));
        chk("d_stall", 32'(d_stall), 32'(d_req && win != 2));
`ifdef MEM_ARB_PERF_EN
        chk("perf_cnt", perf_conflict_cnt, m_perf);
`endif
        if (win == 2) begin
            chk("d_mem_addr", mem_addr, d_addr);
            chk("d_mem_we", 32'(mem_we), d_we ? 32'(d_be) : 0);
            if (d_we) begin
                chk("d_mem_wdata", mem_wdata, d_wdata);
                sb.push_back('{side: 2, data: 32'd0});
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) mem[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
                sb.push_back('{side: 2, data: mem[d_addr[5:2]]});
            end
            m_addr = d_addr;
        end else if (win == 1) begin
            chk("i_mem_addr", mem_addr, i_addr);
            chk("i_mem_we", 32'(mem_we), 0);
            sb.push_back('{side: 1, data: mem[i_addr[5:2]]});
            m_addr = i_addr;
        end
        if (i_req && d_req) m_perf = m_perf + 1;
        if (win == 1 || !i_req) m_run = 0;
        else if (win == 2 && m_run < MAXB) m_run++;
        if (win != 0) m_busy = win;
        else if (complete) m_busy = 0;
        hold_i = i_req && win != 1;
        hold_d = d_req && win != 2;
    endtask

    // monitor: retire responses in issue order
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (i_valid || d_valid) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("resp_side", i_valid ? 32'd1 : 32'd2, 32'(e.side));
                    chk("resp_data", i_valid ? i_rdata : d_rdata, e.data);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        repeat (3) cycle(0, 0, 100, 0, 1);
        repeat (20) cycle(100, 0, 100, 0, 0);      // fetch alone
        repeat (40) cycle(100, 100, 100, 50, 0);   // contention: starvation guard
        repeat (30) cycle(0, 100, 100, 0, 0);      // back-to-back loads
        repeat (40) cycle(100, 100, 25, 30, 0);    // wait states
        repeat (5)  cycle(0, 0, 100, 0, 0);
        cycle(0, 100, 100, 0, 0);                  // issue a data access
        repeat (3) cycle(0, 0, 0, 0, 0);           // memory holds it
        cycle(0, 0, 0, 0, 1);                      // reset mid-access
        repeat (3) cycle(0, 0, 100, 0, 0);         // late ready must be ignored
        for (int n = 0; n < 1500; n++)
            cycle(60, 60, 60, 40, ($urandom_range(99) == 0));
        repeat (6) cycle(0, 0, 100, 0, 0);
        @(negedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
